// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single FIFO write port.
// Each grant lasts up to MAX_BURST writes and is followed by a one-cycle arbitration bubble.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_wdata,
    input  logic                        i_full,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_ack,
    output logic                        o_wr,
    output logic [DATA_WIDTH-1:0]       o_wdata,
    output logic                        o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 gnt_req;
    logic [DATA_WIDTH-1:0] masked_data [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign o_ack[gi]       = gnt_q[gi] & i_req[gi] & ~i_full;
            assign masked_data[gi] = gnt_q[gi] ? i_wdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_req[(int'(ptr_q) + i) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        o_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_wdata = o_wdata | masked_data[k];
        end
    end

    assign o_gnt   = gnt_q;
    assign o_wr    = |o_ack;
    assign o_busy  = (state_q == S_BURST);
    assign gnt_req = |(gnt_q & i_req);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_BURST;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    win_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            S_BURST: begin
                if (o_wr) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A full FIFO only stalls; the burst ends on the last write or a dropped request.
                if (!gnt_req || (o_wr && (cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = win_q;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
